// File: rtl/ads1292_filter_pkg.sv
// Shared definitions for the multi-channel ADS1292 filter chain:
// sequencer state encoding, bus widths and sample scaling helpers.
package ads1292_filter_pkg;

    localparam int unsigned CH_IDX_W  = 3;   // channel index on stage/output buses
    localparam int unsigned CH_CNT_W  = 4;   // internal channel counter, must reach NUM_CH (8)
    localparam int unsigned STG_IDX_W = 4;   // stage index, must reach NUM_STG (8)
    localparam int unsigned FLOAT_W   = 32;  // stage data bus width

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL_CH   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_Y   = 3'd3,
        ST_NEXT_STG = 3'd4,
        ST_OUT      = 3'd5
    } state_e;

    // Left-justify an in_w-bit sample (zero-extended in x) into the 32-bit stage word.
    function automatic logic [FLOAT_W-1:0] scale_up(input logic [FLOAT_W-1:0] x,
                                                    input int unsigned       in_w);
        return x << (FLOAT_W - in_w);
    endfunction

    // Recover the in_w-bit sample from the top of a 32-bit stage word.
    function automatic logic [FLOAT_W-1:0] scale_down(input logic [FLOAT_W-1:0] x,
                                                      input int unsigned       in_w);
        return x >> (FLOAT_W - in_w);
    endfunction

endpackage

// File: rtl/ads1292_stage_sel.sv
// Combinational priority finder: lowest enabled stage index >= from_i.
// Ports:
//   mask_i  stage enable mask
//   from_i  first index considered (inclusive)
//   idx_o   selected stage index (0 when none)
//   none_o  1 when no enabled stage at or above from_i
module ads1292_stage_sel
    import ads1292_filter_pkg::*;
#(
    parameter int unsigned NUM_STG = 5
) (
    input  logic [NUM_STG-1:0]   mask_i,
    input  logic [STG_IDX_W-1:0] from_i,
    output logic [STG_IDX_W-1:0] idx_o,
    output logic                 none_o
);

    // Scan downwards so the lowest qualifying index wins.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = NUM_STG - 1; i >= 0; i--) begin
            if (mask_i[i] && (STG_IDX_W'(i) >= from_i)) begin
                idx_o  = STG_IDX_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ads1292_filter_chain_mc.sv
// Multi-channel ADS1292 filter sequencer. Latches one frame, then runs each
// enabled channel through the enabled processing stages over valid/ready/ack
// handshakes and emits one filtered sample per channel.
// Ports:
//   i_CLK, i_RSTN                      clock, async active-low reset
//   i_DATA, i_DATA_VALID               input frame and one-cycle strobe
//   i_CH_EN, i_STG_EN                  channel / stage enable masks (latched per frame)
//   o_STG_X, o_STG_CH, o_STG_X_VALID   shared stage input bus, one-hot strobe
//   i_STG_X_READY                      per-stage input ready
//   i_STG_Y, i_STG_Y_VALID, o_STG_Y_ACK  per-stage result, valid, one-hot ack
//   o_DATA, o_CH, o_DATA_VALID, i_DATA_ACK  output sample, held until ack
//   o_BUSY                             frame in progress
//   o_OVERRUN, o_TIMEOUT_ERR, i_ERR_CLR  sticky error flags and their clear
module ads1292_filter_chain_mc
    import ads1292_filter_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned NUM_STG = 5,
    parameter int unsigned IN_W    = 24,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                       i_CLK,
    input  logic                       i_RSTN,
    input  logic [NUM_CH*IN_W-1:0]     i_DATA,
    input  logic                       i_DATA_VALID,
    input  logic [NUM_CH-1:0]          i_CH_EN,
    input  logic [NUM_STG-1:0]         i_STG_EN,
    output logic [FLOAT_W-1:0]         o_STG_X,
    output logic [CH_IDX_W-1:0]        o_STG_CH,
    output logic [NUM_STG-1:0]         o_STG_X_VALID,
    input  logic [NUM_STG-1:0]         i_STG_X_READY,
    input  logic [NUM_STG*FLOAT_W-1:0] i_STG_Y,
    input  logic [NUM_STG-1:0]         i_STG_Y_VALID,
    output logic [NUM_STG-1:0]         o_STG_Y_ACK,
    output logic [IN_W-1:0]            o_DATA,
    output logic [CH_IDX_W-1:0]        o_CH,
    output logic                       o_DATA_VALID,
    input  logic                       i_DATA_ACK,
    output logic                       o_BUSY,
    output logic                       o_OVERRUN,
    output logic                       o_TIMEOUT_ERR,
    input  logic                       i_ERR_CLR
);

    localparam int unsigned   FRAME_W = NUM_CH * IN_W;
    localparam int unsigned   WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [NUM_CH-1:0]      ch_en_q, ch_en_d;
    logic [NUM_STG-1:0]     stg_en_q, stg_en_d;
    logic [CH_CNT_W-1:0]    ch_q, ch_d;
    logic [STG_IDX_W-1:0]   stg_q, stg_d;
    logic [FLOAT_W-1:0]     acc_q, acc_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [FLOAT_W-1:0]     stg_x_q, stg_x_d;
    logic [CH_IDX_W-1:0]    stg_ch_q, stg_ch_d;
    logic [NUM_STG-1:0]     stg_xv_q, stg_xv_d;
    logic [NUM_STG-1:0]     stg_ack_q, stg_ack_d;
    logic [IN_W-1:0]        data_q, data_d;
    logic [CH_IDX_W-1:0]    out_ch_q, out_ch_d;
    logic                   dv_q, dv_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic                   tmo_q, tmo_d;

    logic [IN_W-1:0]        cur_sample;
    logic                   cur_ch_en;
    logic                   cur_rdy;
    logic                   cur_yv;
    logic [FLOAT_W-1:0]     cur_y;
    logic [NUM_STG-1:0]     stg_onehot;
    logic [STG_IDX_W-1:0]   first_idx, next_idx;
    logic                   first_none, next_none;
    logic                   tmo_set;

    // Per-channel selection from the latched frame and masks.
    always_comb begin
        cur_sample = '0;
        cur_ch_en  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_CNT_W'(i)) begin
                cur_sample = frame_q[i*IN_W +: IN_W];
                cur_ch_en  = ch_en_q[i];
            end
        end
    end

    // Per-stage selection of handshake inputs for the active stage.
    always_comb begin
        cur_rdy    = 1'b0;
        cur_yv     = 1'b0;
        cur_y      = '0;
        stg_onehot = '0;
        for (int i = 0; i < NUM_STG; i++) begin
            if (stg_q == STG_IDX_W'(i)) begin
                cur_rdy       = i_STG_X_READY[i];
                cur_yv        = i_STG_Y_VALID[i];
                cur_y         = i_STG_Y[i*FLOAT_W +: FLOAT_W];
                stg_onehot[i] = 1'b1;
            end
        end
    end

    ads1292_stage_sel #(.NUM_STG(NUM_STG)) u_first_sel (
        .mask_i (stg_en_q),
        .from_i ('0),
        .idx_o  (first_idx),
        .none_o (first_none)
    );

    ads1292_stage_sel #(.NUM_STG(NUM_STG)) u_next_sel (
        .mask_i (stg_en_q),
        .from_i (stg_q + STG_IDX_W'(1)),
        .idx_o  (next_idx),
        .none_o (next_none)
    );

    // Sequencer next-state and registered output logic.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        ch_en_d   = ch_en_q;
        stg_en_d  = stg_en_q;
        ch_d      = ch_q;
        stg_d     = stg_q;
        acc_d     = acc_q;
        wd_d      = '0;
        stg_x_d   = stg_x_q;
        stg_ch_d  = stg_ch_q;
        stg_xv_d  = '0;
        stg_ack_d = '0;
        data_d    = data_q;
        out_ch_d  = out_ch_q;
        dv_d      = dv_q;
        busy_d    = busy_q;
        tmo_set   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_DATA_VALID) begin
                    frame_d  = i_DATA;
                    ch_en_d  = i_CH_EN;
                    stg_en_d = i_STG_EN;
                    ch_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SEL_CH;
                end
            end
            ST_SEL_CH: begin
                if (ch_q == CH_CNT_W'(NUM_CH)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!cur_ch_en) begin
                    ch_d = ch_q + CH_CNT_W'(1);
                end else begin
                    acc_d    = scale_up(FLOAT_W'(cur_sample), IN_W);
                    stg_x_d  = acc_d;
                    stg_ch_d = CH_IDX_W'(ch_q);
                    stg_d    = first_idx;
                    state_d  = first_none ? ST_OUT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cur_rdy) begin
                    stg_xv_d = stg_onehot;
                    state_d  = ST_WAIT_Y;
                end else if (wd_q == WD_LAST) begin
                    tmo_set = 1'b1;
                    ch_d    = ch_q + CH_CNT_W'(1);
                    state_d = ST_SEL_CH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_WAIT_Y: begin
                if (cur_yv) begin
                    acc_d     = cur_y;
                    stg_ack_d = stg_onehot;
                    state_d   = ST_NEXT_STG;
                end else if (wd_q == WD_LAST) begin
                    tmo_set = 1'b1;
                    ch_d    = ch_q + CH_CNT_W'(1);
                    state_d = ST_SEL_CH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_NEXT_STG: begin
                stg_x_d = acc_q;
                stg_d   = next_idx;
                state_d = next_none ? ST_OUT : ST_ISSUE;
            end
            ST_OUT: begin
                if (!dv_q) begin
                    dv_d     = 1'b1;
                    data_d   = IN_W'(scale_down(acc_q, IN_W));
                    out_ch_d = CH_IDX_W'(ch_q);
                end else if (i_DATA_ACK) begin
                    dv_d    = 1'b0;
                    ch_d    = ch_q + CH_CNT_W'(1);
                    state_d = ST_SEL_CH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A set event wins over a clear in the same cycle.
        ovr_d = (ovr_q & ~i_ERR_CLR) | (i_DATA_VALID & busy_q);
        tmo_d = (tmo_q & ~i_ERR_CLR) | tmo_set;
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            ch_en_q   <= '0;
            stg_en_q  <= '0;
            ch_q      <= '0;
            stg_q     <= '0;
            acc_q     <= '0;
            wd_q      <= '0;
            stg_x_q   <= '0;
            stg_ch_q  <= '0;
            stg_xv_q  <= '0;
            stg_ack_q <= '0;
            data_q    <= '0;
            out_ch_q  <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            ch_en_q   <= ch_en_d;
            stg_en_q  <= stg_en_d;
            ch_q      <= ch_d;
            stg_q     <= stg_d;
            acc_q     <= acc_d;
            wd_q      <= wd_d;
            stg_x_q   <= stg_x_d;
            stg_ch_q  <= stg_ch_d;
            stg_xv_q  <= stg_xv_d;
            stg_ack_q <= stg_ack_d;
            data_q    <= data_d;
            out_ch_q  <= out_ch_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_STG_X       = stg_x_q;
    assign o_STG_CH      = stg_ch_q;
    assign o_STG_X_VALID = stg_xv_q;
    assign o_STG_Y_ACK   = stg_ack_q;
    assign o_DATA        = data_q;
    assign o_CH          = out_ch_q;
    assign o_DATA_VALID  = dv_q;
    assign o_BUSY        = busy_q;
    assign o_OVERRUN     = ovr_q;
    assign o_TIMEOUT_ERR = tmo_q;

endmodule

// File: doc/ads1292_filter_chain_mc.md
Name: ads1292_filter_chain_mc

Overview:
Parametrised multi-channel successor to the single-channel ADS1292 filter sequencer. It captures one ADS1292 frame (NUM_CH channels) and scales each channel to 32 bits. Each channel is then run in turn through a chain of NUM_STG external processing stages (i2f, IIR LPF/notch/HPF, f2i or others) over valid/ready/ack handshakes. Results are emitted one channel at a time, downstream of ads1292_controller and upstream of the packet/UART path. Adds over the previous generation: per-stage bypass, per-channel disable, a stage watchdog, and overrun detection.

Parameters:
NUM_CH, 2, channels per frame (1..8)
NUM_STG, 5, processing stages in chain (1..8)
IN_W, 24, sample width per channel (<=32)
TIMEOUT, 4096, max cycles waiting on any single stage handshake phase

Ports:
i_CLK  in  1  clock
i_RSTN  in  1  reset; one clock, asynchronous, active-low
i_DATA  in  NUM_CH*IN_W  frame; ch0 in [IN_W-1:0]
i_DATA_VALID  in  1  one-cycle frame strobe
i_CH_EN  in  NUM_CH  1 = channel processed; 0 = no output for that channel
i_STG_EN  in  NUM_STG  1 = stage used; 0 = stage bypassed (pass-through, zero cycles)
o_STG_X  out  32  stage input data (shared bus)
o_STG_CH  out  3  channel index of current operation; stages keep per-channel state by it
o_STG_X_VALID  out  NUM_STG  one-hot input strobe
i_STG_X_READY  in  NUM_STG  stage ready for input
i_STG_Y  in  NUM_STG*32  stage outputs
i_STG_Y_VALID  in  NUM_STG  stage output valid
o_STG_Y_ACK  out  NUM_STG  one-hot output ack pulse
o_DATA  out  IN_W  filtered sample
o_CH  out  3  channel of o_DATA
o_DATA_VALID  out  1  output valid; held until ack
i_DATA_ACK  in  1  downstream took o_DATA
o_BUSY  out  1  frame in progress
o_OVERRUN  out  1  sticky: frame strobe arrived while busy
o_TIMEOUT_ERR  out  1  sticky: stage watchdog fired
i_ERR_CLR  in  1  clears both sticky flags

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; frame register 0.
- States: IDLE, SEL_CH, ISSUE, WAIT_Y, NEXT_STG, OUT.
- IDLE: on i_DATA_VALID, latch the whole frame, ch=0, go SEL_CH, assert o_BUSY.
- SEL_CH:
  - if ch==NUM_CH, go IDLE and deassert o_BUSY.
  - if i_CH_EN[ch]==0, ch++ and stay in SEL_CH.
  - else load acc={sample,(32-IN_W)'b0}, stg=first enabled stage; go ISSUE, or go OUT if no stage is enabled.
- ISSUE:
  - o_STG_X=acc, o_STG_CH=ch.
  - when i_STG_X_READY[stg]: pulse o_STG_X_VALID[stg] for exactly 1 cycle, then go WAIT_Y.
- WAIT_Y:
  - when i_STG_Y_VALID[stg]: acc=i_STG_Y[stg]; pulse o_STG_Y_ACK[stg] for 1 cycle (next cycle); go NEXT_STG.
  - stage must drop Y_VALID after the ack.
- NEXT_STG: stg=next enabled stage above stg; go ISSUE, or go OUT if none remain.
- OUT:
  - o_DATA=acc[31:32-IN_W], o_CH=ch, o_DATA_VALID=1.
  - on valid&&i_DATA_ACK: valid=0, ch++, go SEL_CH.
  - ack may arrive in the first valid cycle.
- Stage enable mask and channel enable mask are sampled at frame latch; mid-frame changes are ignored.
- Watchdog:
  - counter resets on entry to ISSUE and to WAIT_Y.
  - if the counter reaches TIMEOUT in either state: set o_TIMEOUT_ERR, drop no strobe, emit nothing for that channel, ch++, go SEL_CH.
  - the remaining channels still run.
- Overrun: i_DATA_VALID while o_BUSY sets o_OVERRUN; the new frame is dropped and the current frame is not disturbed.
- Flag priority: i_ERR_CLR and a set event in the same cycle leave the flag set.
- Latency per channel: 2 cycles plus stage latencies. All stages bypassed gives o_DATA_VALID 3 cycles after the strobe for ch0.
- Async reset mid-frame returns to IDLE at once with all strobes and acks low. Stage state is cleared by the stages' own resets.

Decomposition:
- Package ads1292_filter_pkg: state encoding, CH_IDX_W=3, FLOAT_W=32, scale helper functions (up/down shift by 32-IN_W).
- Sub-module ads1292_stage_sel: combinational next-enabled-stage priority finder (mask, current index -> next index, none flag).
- Use it twice: for the first-stage search and in NEXT_STG.

Test Plan:
- NUM_CH=2, all stages bypassed, frame {ch1=24'h000010, ch0=24'h7FFFFF} -> outputs (ch0,7FFFFF) then (ch1,000010); first valid 3 cycles after strobe.
- All 5 stubs add 32'h100 with 4-cycle latency, input 24'h000001 -> output 24'h000006; exactly one X_VALID and one Y_ACK pulse per stage per channel.
- i_STG_EN=5'b10101, same stubs -> output input+3; stages 1 and 3 never strobed.
- i_CH_EN=2'b10 -> only ch1 emitted; o_BUSY falls after its ack.
- Stage 2 never asserts Y_VALID, TIMEOUT=16 -> o_TIMEOUT_ERR=1, ch0 dropped, ch1 still emitted via stage 2 stub recovering.
- Second i_DATA_VALID during processing, then i_ERR_CLR -> o_OVERRUN=1, original frame outputs unchanged, flag 0 after clear; reset asserted mid-WAIT_Y -> all outputs 0 immediately.
